// File: rtl/retire_trace_buffer_pkg.sv
// retire_trace_buffer_pkg
//   Shared types and constants for the retirement trace buffer.
//   - XLEN            : datapath width of the RV32I core.
//   - TRACE_DEPTH_DEF : default FIFO depth of the trace buffer.
//   - retire_rec_t    : one packed retirement record (5*XLEN+6 bits).
//   - pack_retire_rec : assembles a record from the individual retire fields.
package retire_trace_buffer_pkg;

  localparam int XLEN            = 32;
  localparam int TRACE_DEPTH_DEF = 16;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } retire_rec_t;

  localparam int RETIRE_REC_W = $bits(retire_rec_t);

  function automatic retire_rec_t pack_retire_rec(
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] instr,
    input logic [4:0]      reg_addr,
    input logic [XLEN-1:0] reg_data,
    input logic [XLEN-1:0] mem_addr,
    input logic [XLEN-1:0] mem_data,
    input logic            mem_wrt
  );
    retire_rec_t rec;
    rec.pc       = pc;
    rec.instr    = instr;
    rec.reg_addr = reg_addr;
    rec.reg_data = reg_data;
    rec.mem_addr = mem_addr;
    rec.mem_data = mem_data;
    rec.mem_wrt  = mem_wrt;
    return rec;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with occupancy counter, no read bypass.
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset
//     flush_i        : empties the FIFO next cycle, overrides push/pop
//     push_i         : write request; accepted when not full or when a pop
//                      happens in the same cycle
//     pop_i          : read request; ignored while empty
//     wdata_i        : write data
//     rdata_o        : head entry (mem[rd_ptr]); meaningful only when !empty_o
//     count_o        : occupancy, 0..DEPTH
//     full_o/empty_o : derived from count_o
//     push_acc_o     : this cycle's push is being accepted
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     push_acc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en, mem_we;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rdata_o    = mem_q[rd_ptr_q];
  assign push_acc_o = push_en;

  always_comb begin
    pop_en   = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_en  = push_i && (!full_o || pop_en) && !flush_i;
    mem_we   = push_en;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Captures one retirement record per cycle from the core into a bounded
//   FIFO drained by a downstream consumer. The core is never stalled: when the
//   FIFO is full and the head is not leaving, the new record is dropped,
//   a saturating drop counter increments and a sticky overflow flag sets.
//   Ports:
//     clk_i, rst_i         : clock, synchronous active-high reset
//     retire_valid_i, pc_i, instr_i, reg_addr_i, reg_data_i,
//     mem_addr_i, mem_data_i, mem_wrt_i : retire record from the core
//     flush_i              : discard all buffered records (counters kept)
//     out_valid_o/out_ready_i/out_rec_o : consumer handshake
//     count_o              : occupancy
//     drop_cnt_o           : saturating count of dropped records
//     overflow_o           : sticky, set on the first drop
//
//   Handshake: a record transfers on a rising clk_i edge where out_valid_o
//   and out_ready_i are both 1. out_valid_o depends only on registered state,
//   never on out_ready_i, and out_rec_o is stable while out_valid_o=1 and
//   out_ready_i=0. A record pushed at an edge is first presented after that
//   edge (no same-cycle bypass).
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH      = TRACE_DEPTH_DEF,
  parameter int DROP_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   retire_valid_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [4:0]             reg_addr_i,
  input  logic [XLEN-1:0]        reg_data_i,
  input  logic [XLEN-1:0]        mem_addr_i,
  input  logic [XLEN-1:0]        mem_data_i,
  input  logic                   mem_wrt_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output retire_rec_t            out_rec_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o,
  output logic                   overflow_o
);

  retire_rec_t           in_rec;
  logic [RETIRE_REC_W-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty, push_acc;
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  overflow_q, overflow_d;

  assign in_rec = pack_retire_rec(pc_i, instr_i, reg_addr_i, reg_data_i,
                                  mem_addr_i, mem_data_i, mem_wrt_i);

  sync_fifo #(
    .WIDTH (RETIRE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_i     (retire_valid_i),
    .pop_i      (out_ready_i),
    .wdata_i    (in_rec),
    .rdata_o    (fifo_rdata),
    .count_o    (count_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .push_acc_o (push_acc)
  );

  assign out_valid_o = !fifo_empty;
  assign out_rec_o   = retire_rec_t'(fifo_rdata);

  always_comb begin
    // A push discarded by flush is not a loss; only a rejected push counts.
    drop       = retire_valid_i && !push_acc && !flush_i;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {DROP_CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;
  import retire_trace_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int DCW   = 4;
  localparam int REC_W = $bits(retire_rec_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_i = 1'b1;
  logic                   retire_valid_i = 1'b0;
  logic [XLEN-1:0]        pc_i = '0, instr_i = '0, reg_data_i = '0;
  logic [XLEN-1:0]        mem_addr_i = '0, mem_data_i = '0;
  logic [4:0]             reg_addr_i = '0;
  logic                   mem_wrt_i = 1'b0;
  logic                   flush_i = 1'b0;
  logic                   out_ready_i = 1'b0;
  logic                   out_valid_o;
  retire_rec_t            out_rec_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [DCW-1:0]         drop_cnt_o;
  logic                   overflow_o;

  retire_trace_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
    .clk_i(clk), .rst_i(rst_i), .retire_valid_i(retire_valid_i),
    .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i),
    .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_wrt_i(mem_wrt_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_rec_o(out_rec_o), .count_o(count_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  // ---------------- scoreboard state ----------------
  logic [REC_W-1:0] exp_q[$];
  int cmp_cnt = 0;
  int err_cnt = 0;
  int mcount  = 0;   // bench model of occupancy

  function automatic retire_rec_t mk_rec(input logic [31:0] pc);
    retire_rec_t r;
    r.pc       = pc;
    r.instr    = pc ^ 32'h0000_0013;
    r.reg_addr = pc[6:2];
    r.reg_data = pc * 3;
    r.mem_addr = pc + 32'h1000;
    r.mem_data = ~pc;
    r.mem_wrt  = pc[2];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  // Samples at negedge; a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
      cmp_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL out_rec unexpected: got pc %0h expected none", out_rec_o.pc);
      end else begin
        logic [REC_W-1:0] e;
        e = exp_q.pop_front();
        if (out_rec_o !== e) begin
          err_cnt++;
          $display("FAIL out_rec: got %h expected %h", out_rec_o, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle, updates the model at the edge,
  // returns at the following posedge+1.
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                      input logic fl, input logic rs);
    retire_rec_t r;
    logic pop, acc;
    r = mk_rec(pc);
    retire_valid_i = v;
    pc_i = r.pc; instr_i = r.instr; reg_addr_i = r.reg_addr;
    reg_data_i = r.reg_data; mem_addr_i = r.mem_addr; mem_data_i = r.mem_data;
    mem_wrt_i = r.mem_wrt;
    out_ready_i = rdy; flush_i = fl; rst_i = rs;
    pop = rdy && (mcount > 0);
    acc = v && ((mcount < DEPTH) || pop);
    @(posedge clk);
    if (rs || fl) begin
      mcount = 0;
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back(r);
      mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (mcount > 0 && guard < 4 * DEPTH) begin
      idle(1'b1);
      guard++;
    end
    chk("drain_done", 32'(mcount), 32'd0);
    idle(1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pushed, guard;
    logic rdy, v;

    // reset
    @(posedge clk); #1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);

    // three pushes, no drain
    step(1'b1, 32'h04, 1'b0, 1'b0, 1'b0);
    chk("first_valid", 32'(out_valid_o), 32'd1);
    chk("first_pc", out_rec_o.pc, 32'h04);
    step(1'b1, 32'h08, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0C, 1'b0, 1'b0, 1'b0);
    chk("count3", 32'(count_o), 32'd3);

    // overfill: DEPTH+2 pushes total, last two dropped
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 32'h10 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count_o), 32'(DEPTH));
    chk("full_drop", 32'(drop_cnt_o), 32'd2);
    chk("full_ovf", 32'(overflow_o), 32'd1);
    chk("full_head", out_rec_o.pc, 32'h04);

    // full + push + pop: accepted, not a drop
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    chk("fpp_count", 32'(count_o), 32'(DEPTH));
    chk("fpp_drop", 32'(drop_cnt_o), 32'd2);
    chk("fpp_head", out_rec_o.pc, 32'h08);
    drain();
    chk("empty_valid", 32'(out_valid_o), 32'd0);

    // streaming with random ready, never pushing into a full non-popping FIFO
    pushed = 0; guard = 0;
    while (pushed < 100 && guard < 2000) begin
      rdy = ($urandom_range(0, 3) != 0);
      v   = ($urandom_range(0, 3) != 0) && ((mcount < DEPTH) || (rdy && mcount > 0));
      step(v, 32'h1000 + 32'(4 * pushed), rdy, 1'b0, 1'b0);
      if (v) pushed++;
      chk("stream_count", 32'(count_o), 32'(mcount));
      guard++;
    end
    chk("stream_pushed", 32'(pushed), 32'd100);
    drain();
    chk("stream_drop", 32'(drop_cnt_o), 32'd2);

    // flush with 5 buffered and a concurrent push
    for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count_o), 32'd5);
    step(1'b1, 32'h2F0, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    chk("flush_drop", 32'(drop_cnt_o), 32'd2);
    chk("flush_ovf", 32'(overflow_o), 32'd1);

    // empty + push + ready: no bypass
    step(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    chk("nobyp_count", 32'(count_o), 32'd1);
    chk("nobyp_pc", out_rec_o.pc, 32'h300);
    drain();

    // reach drop_cnt=7, then reset mid-stream
    for (int i = 0; i < DEPTH + 5; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_drop", 32'(drop_cnt_o), 32'd7);
    step(1'b1, 32'h4F0, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_o), 32'd0);
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(out_valid_o), 32'd1);
    chk("post_rst_pc", out_rec_o.pc, 32'h500);
    drain();

    // saturate the drop counter
    for (int i = 0; i < DEPTH + 15; i++) step(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_cnt_o), 32'hF);
    step(1'b1, 32'h6F0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", 32'(drop_cnt_o), 32'hF);
    chk("sat_head", out_rec_o.pc, 32'h600);
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
